// File: rtl/branch_cond_resolver_pkg.sv
// Shared types and constants for the branch condition resolver and its
// condition evaluator.
package branch_cond_resolver_pkg;

    typedef enum logic [1:0] {
        BR_B    = 2'd0,
        BR_COND = 2'd1,
        BR_CBZ  = 2'd2,
        BR_CBNZ = 2'd3
    } br_kind_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_cond_resolver_cond_eval.sv
// Combinational ARM condition-code evaluator: returns whether the given
// condition passes for the supplied N, Z, C, V flags.
module branch_cond_resolver_cond_eval
    import branch_cond_resolver_pkg::*;
(
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    input  logic [3:0] cond,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_resolver.sv
// Resolves B, B.cond, CBZ and CBNZ in decode using forwarded flags, and issues
// a registered PC redirect followed by a fixed-length IF/ID flush.
module branch_cond_resolver
    import branch_cond_resolver_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              br_valid,
    input  logic [1:0]        br_kind,
    input  logic [3:0]        br_cond,
    input  logic [DATA_W-1:0] br_reg,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    input  logic              negativeC,
    input  logic              zeroC,
    input  logic              overflowC,
    input  logic              carry_outC,
    input  logic              ex_setflags,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic              ex_overflow,
    input  logic              ex_carry_out,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic              flush,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt
);

    state_t                 state;
    state_t                 next_state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic                   eff_n;
    logic                   eff_z;
    logic                   eff_c;
    logic                   eff_v;
    logic                   cond_pass;
    logic                   taken;
    logic                   accept;
    br_kind_t               kind;

    // Execute-stage flag writes bypass the flag register in the same cycle.
    always_comb begin
        eff_n = ex_setflags ? ex_negative  : negativeC;
        eff_z = ex_setflags ? ex_zero      : zeroC;
        eff_c = ex_setflags ? ex_carry_out : carry_outC;
        eff_v = ex_setflags ? ex_overflow  : overflowC;
    end

    branch_cond_resolver_cond_eval u_cond_eval (
        .n    (eff_n),
        .z    (eff_z),
        .c    (eff_c),
        .v    (eff_v),
        .cond (br_cond),
        .pass (cond_pass)
    );

    assign kind   = br_kind_t'(br_kind);
    assign accept = br_valid & br_ready;

    always_comb begin
        taken = 1'b0;
        case (kind)
            BR_B:    taken = 1'b1;
            BR_COND: taken = cond_pass;
            BR_CBZ:  taken = (br_reg == '0);
            BR_CBNZ: taken = (br_reg != '0);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && taken) begin
                    next_state = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // redirect_valid and flush are pure decodes of the registered state.
    always_comb begin
        br_ready       = (state == IDLE);
        redirect_valid = (state == REDIRECT);
        flush          = (state == FLUSH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_pc <= '0;
            flush_cnt   <= '0;
        end else begin
            if (state == IDLE && accept && taken) begin
                redirect_pc <= br_target;
            end
            if (state == REDIRECT && redirect_ready) begin
                flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (accept) begin
            if (taken) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end else begin
                nottaken_cnt <= nottaken_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_resolver.sv
// Self-checking bench for branch_cond_resolver: directed scenarios plus
// randomized branches against a behavioural model of the resolver.
module tb_branch_cond_resolver;

    localparam int ADDR_W       = 64;
    localparam int DATA_W       = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              br_valid;
    logic [1:0]        br_kind;
    logic [3:0]        br_cond;
    logic [DATA_W-1:0] br_reg;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              negativeC, zeroC, overflowC, carry_outC;
    logic              ex_setflags, ex_negative, ex_zero, ex_overflow, ex_carry_out;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              redirect_ready;
    logic              flush;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nottaken_cnt;

    int compared   = 0;
    int mismatched = 0;
    int exp_taken  = 0;
    int exp_ntaken = 0;
    logic [ADDR_W-1:0] exp_pc = '0;

    branch_cond_resolver #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .br_valid       (br_valid),
        .br_kind        (br_kind),
        .br_cond        (br_cond),
        .br_reg         (br_reg),
        .br_target      (br_target),
        .br_ready       (br_ready),
        .negativeC      (negativeC),
        .zeroC          (zeroC),
        .overflowC      (overflowC),
        .carry_outC     (carry_outC),
        .ex_setflags    (ex_setflags),
        .ex_negative    (ex_negative),
        .ex_zero        (ex_zero),
        .ex_overflow    (ex_overflow),
        .ex_carry_out   (ex_carry_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .taken_cnt      (taken_cnt),
        .nottaken_cnt   (nottaken_cnt)
    );

    always #5 clk = ~clk;

    // ARM encoding view: bits [3:1] select a base test, bit 0 inverts it (except 1111).
    function automatic bit model_taken(input int kind, input int cond, input logic [DATA_W-1:0] r,
                                       input bit n, input bit z, input bit c, input bit v);
        bit base;
        case (kind)
            0: return 1'b1;
            2: return (r == 0);
            3: return (r != 0);
            default: begin
                case (cond / 2)
                    0: base = z;
                    1: base = c;
                    2: base = n;
                    3: base = v;
                    4: base = c && !z;
                    5: base = (n == v);
                    6: base = !z && (n == v);
                    default: base = 1'b1;
                endcase
                if ((cond % 2) == 1 && cond != 15) base = !base;
                return base;
            end
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " br_ready"}, 64'(br_ready), 64'd1);
        checkOutput({tag, " redirect_valid"}, 64'(redirect_valid), 64'd0);
        checkOutput({tag, " flush"}, 64'(flush), 64'd0);
        checkOutput({tag, " taken_cnt"}, 64'(taken_cnt), 64'(exp_taken));
        checkOutput({tag, " nottaken_cnt"}, 64'(nottaken_cnt), 64'(exp_ntaken));
    endtask

    // Presents one branch from IDLE (called #1 after a rising edge), then walks
    // the redirect handshake and flush window when the model says it is taken.
    task automatic applyStimulus(input string tag, input int kind, input int cond,
                                 input logic [DATA_W-1:0] r, input logic [ADDR_W-1:0] tgt,
                                 input bit sn, input bit sz, input bit sc, input bit sv,
                                 input bit xs, input bit xn, input bit xz, input bit xc, input bit xv,
                                 input int ready_delay);
        bit tk;
        bit en, ez, ec, ev;
        en = xs ? xn : sn;
        ez = xs ? xz : sz;
        ec = xs ? xc : sc;
        ev = xs ? xv : sv;
        tk = model_taken(kind, cond, r, en, ez, ec, ev);
        br_valid = 1'b1; br_kind = 2'(kind); br_cond = 4'(cond);
        br_reg = r; br_target = tgt;
        negativeC = sn; zeroC = sz; carry_outC = sc; overflowC = sv;
        ex_setflags = xs; ex_negative = xn; ex_zero = xz; ex_carry_out = xc; ex_overflow = xv;
        @(posedge clk); #1;
        br_valid = 1'b0;
        // Scramble flags so the result must come from the accept cycle only.
        ex_setflags = 1'b1; ex_negative = ~xn; ex_zero = ~xz; ex_carry_out = ~xc; ex_overflow = ~xv;
        if (tk) begin
            exp_taken = (exp_taken + 1) % (1 << CNT_W);
            exp_pc = tgt;
        end else begin
            exp_ntaken = (exp_ntaken + 1) % (1 << CNT_W);
        end
        checkOutput({tag, " redirect_valid"}, 64'(redirect_valid), 64'(tk));
        checkOutput({tag, " redirect_pc"}, redirect_pc, exp_pc);
        checkOutput({tag, " taken_cnt"}, 64'(taken_cnt), 64'(exp_taken));
        checkOutput({tag, " nottaken_cnt"}, 64'(nottaken_cnt), 64'(exp_ntaken));
        if (tk) begin
            for (int i = 0; i < ready_delay; i++) begin
                br_valid = 1'b1; br_kind = 2'd0; br_target = ~tgt;
                @(posedge clk); #1;
                checkOutput({tag, " held redirect_valid"}, 64'(redirect_valid), 64'd1);
                checkOutput({tag, " held redirect_pc"}, redirect_pc, exp_pc);
                checkOutput({tag, " held br_ready"}, 64'(br_ready), 64'd0);
            end
            br_valid = 1'b0;
            redirect_ready = 1'b1;
            @(posedge clk); #1;
            redirect_ready = 1'b0;
            for (int i = 0; i < FLUSH_CYCLES; i++) begin
                checkOutput({tag, " flush"}, 64'(flush), 64'd1);
                checkOutput({tag, " flush redirect_valid"}, 64'(redirect_valid), 64'd0);
                checkOutput({tag, " flush br_ready"}, 64'(br_ready), 64'd0);
                @(posedge clk); #1;
            end
        end
        checkIdle({tag, " after"});
    endtask

    initial begin
        reset_n = 1'b0;
        br_valid = 1'b0; br_kind = '0; br_cond = '0; br_reg = '0; br_target = '0;
        negativeC = 1'b0; zeroC = 1'b0; overflowC = 1'b0; carry_outC = 1'b0;
        ex_setflags = 1'b0; ex_negative = 1'b0; ex_zero = 1'b0; ex_overflow = 1'b0; ex_carry_out = 1'b0;
        redirect_ready = 1'b0;
        #23;
        checkOutput("reset redirect_valid", 64'(redirect_valid), 64'd0);
        checkOutput("reset redirect_pc", redirect_pc, 64'd0);
        checkOutput("reset flush", 64'(flush), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkIdle("post reset");

        // Reset asserted mid-flush aborts everything at once.
        applyStimulus("pre-abort", 0, 0, 64'd1, 64'h1234, 0,0,0,0, 0,0,0,0,0, 0);
        br_valid = 1'b1; br_kind = 2'd0; br_target = 64'h8000;
        @(posedge clk); #1;
        br_valid = 1'b0; redirect_ready = 1'b1;
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        checkOutput("abort in flush", 64'(flush), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        exp_taken = 0; exp_ntaken = 0; exp_pc = '0;
        checkOutput("abort flush", 64'(flush), 64'd0);
        checkOutput("abort redirect_valid", 64'(redirect_valid), 64'd0);
        checkOutput("abort redirect_pc", redirect_pc, 64'd0);
        checkOutput("abort taken_cnt", 64'(taken_cnt), 64'd0);
        checkOutput("abort nottaken_cnt", 64'(nottaken_cnt), 64'd0);
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        checkIdle("abort release");
        @(posedge clk); #1;
        checkIdle("abort settle");

        // Directed condition and forwarding cases.
        applyStimulus("EQ stored Z", 1, 0, 64'd5, 64'h400, 0,1,0,0, 0,0,0,0,0, 0);
        applyStimulus("EQ fwd Z=0", 1, 0, 64'd5, 64'h500, 0,1,0,0, 1,0,0,0,0, 0);
        applyStimulus("GE N1V0", 1, 10, 64'd5, 64'h600, 1,0,0,0, 0,0,0,0,0, 0);
        applyStimulus("LT N1V0", 1, 11, 64'd5, 64'h700, 1,0,0,0, 0,0,0,0,0, 0);
        applyStimulus("CBZ zero", 2, 0, 64'd0, 64'h800, 0,0,0,0, 0,0,0,0,0, 0);
        applyStimulus("CBNZ zero", 3, 0, 64'd0, 64'h900, 0,0,0,0, 0,0,0,0,0, 0);
        applyStimulus("B stall3", 0, 0, 64'd0, 64'hA00, 0,0,0,0, 0,0,0,0,0, 3);

        // Drive taken_cnt to all-ones, then one more taken branch wraps it.
        while (exp_taken != (1 << CNT_W) - 1) begin
            applyStimulus("fill", 0, 0, 64'd0, 64'(exp_taken) << 4, 0,0,0,0, 0,0,0,0,0, 0);
        end
        applyStimulus("wrap", 0, 0, 64'd0, 64'hBEEF0, 0,0,0,0, 0,0,0,0,0, 0);
        checkOutput("wrap taken_cnt zero", 64'(taken_cnt), 64'd0);

        for (int i = 0; i < 80; i++) begin
            logic [DATA_W-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
            applyStimulus("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), r,
                          {$urandom, $urandom},
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
